resp_bus_arbiter: RTL and testbench
===================================

Name: resp_bus_arbiter

Overview:
- Owns the shared coherence response bus.
- Collects resp_bus_req/resp_bus_tx from every agent: the L1 controllers, the L2 coherence controller and the memory-side agent.
- Picks one winner round-robin and returns resp_bus_gnt to it.
- Broadcasts the winner's message to all agents on resp_bus_msg for exactly one cycle.
- Holds the bus idle while any agent asserts resp_bus_busy.

Parameters:
- NUM_AGENTS, 4, number of bus agents; agent index equals the agent's source ID in resp_msg_t.
- AGENT_W, $clog2(NUM_AGENTS) (min 1), width of the round-robin pointer and winner index.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- resp_bus_req  in  NUM_AGENTS  per-agent bus request; level, held until the agent sees its own message broadcast.
- resp_bus_tx  in  NUM_AGENTS x resp_msg_t  per-agent candidate message; sampled only when that agent wins.
- resp_bus_busy  in  NUM_AGENTS  per-agent stall; while any bit is set, no new grant is issued.
- resp_bus_gnt  out  NUM_AGENTS  one-hot grant; asserted in the same cycle the winner's message is on the bus.
- resp_bus_msg  out  resp_msg_t  broadcast message, registered.

Behaviour:
- Reset (async, rst_n=0): state=ARB_IDLE, rr_ptr=0, resp_bus_gnt=0, resp_bus_msg='0 (valid=0). All take effect immediately, independent of clk.
- Reset released mid-transaction: the in-flight broadcast is lost; agents still holding req re-arbitrate from rr_ptr=0.

State machine (arb_state_t):
- ARB_IDLE: if |resp_bus_req and !(|resp_bus_busy), the picker selects winner w.
  - Search order: first set req bit starting at rr_ptr, wrapping NUM_AGENTS-1 -> 0.
  - Latch msg_q <= resp_bus_tx[w] with valid forced to 1; go to ARB_BCAST.
  - Otherwise stay in ARB_IDLE.
- ARB_BCAST (exactly 1 cycle):
  - resp_bus_gnt = one-hot(w); resp_bus_msg = msg_q.
  - rr_ptr <= (w==NUM_AGENTS-1) ? 0 : w+1.
  - Next state: ARB_HOLD if |resp_bus_busy, else ARB_IDLE.
- ARB_HOLD: gnt=0, resp_bus_msg.valid=0; stay while |resp_bus_busy, then go to ARB_IDLE.
- Outside ARB_BCAST, gnt=0 and resp_bus_msg.valid=0. The remaining resp_bus_msg fields hold their last value and are don't-care.

Latency and throughput:
- Request to grant/broadcast: 1 cycle from the IDLE sample.
- Minimum spacing between broadcasts: 2 cycles (IDLE, BCAST). This lets agents drop req combinationally on seeing their own source on the bus before the next arbitration.

Boundary rules:
- Winner's req drops during ARB_BCAST: broadcast still completes, since msg_q is already latched.
- A non-winner's req/tx changes during BCAST/HOLD: ignored until the next IDLE sample.
- busy asserted in the same cycle as IDLE with req: no grant (busy wins).
- Busy asserted by the winner itself during BCAST: enter ARB_HOLD.
- All reqs set simultaneously: service order is strictly rr_ptr, rr_ptr+1, ...; every agent is served within NUM_AGENTS broadcasts (no starvation).
- NUM_AGENTS=1: rr_ptr is constant 0; behaviour is otherwise identical.
- resp_bus_gnt is never multi-hot. resp_bus_msg.valid is never high for two consecutive cycles.

Decomposition:
- In package cache_types: resp_msg_t (shared, unchanged) and the new enum arb_state_t {ARB_IDLE, ARB_BCAST, ARB_HOLD}.
- Sub-module rr_priority_picker (combinational): inputs req vector and rr_ptr; outputs found and winner index.
- The arbiter itself holds the FSM, rr_ptr, w_q and msg_q.

Test Plan:
- Single request: agent 2 asserts req with tx.addr=0x40, mmsg=DATA in cycle 0 (IDLE) -> cycle 1: gnt=4'b0100, resp_bus_msg.valid=1, addr=0x40; cycle 2: valid=0, rr_ptr=3.
- All-request fairness: reqs 4'b1111 held, each agent dropping its req after its own broadcast, from reset -> broadcast sources in order 0,1,2,3 on cycles 1,3,5,7; gnt one-hot each time.
- Wrap-around: rr_ptr=3, reqs 4'b1001 -> agent 3 wins first, then agent 0; rr_ptr returns to 1.
- Busy stall: agent 1 req with agent 3 busy held 5 cycles -> no gnt until busy deasserts, then gnt=4'b0010 one cycle later. A busy raised during BCAST -> ARB_HOLD for its full duration, then IDLE.
- Winner drops req during BCAST; agent 0 changes tx mid-BCAST -> broadcast data equals the value latched at IDLE.
- Async reset during ARB_BCAST (rst_n low mid-cycle) -> gnt=0 and valid=0 immediately without a clock edge; after release, rr_ptr=0 and the first winner is the lowest set req.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared coherence types: response message format and response-bus arbiter states.
package cache_types;

    // Widest source ID carried in a response message (up to 16 agents).
    localparam int SRC_W  = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        MMSG_NONE = 2'd0,
        MMSG_DATA = 2'd1,
        MMSG_ACK  = 2'd2,
        MMSG_NACK = 2'd3
    } mmsg_t;

    typedef struct packed {
        logic              valid;
        logic [SRC_W-1:0]  src;
        mmsg_t             mmsg;
        logic [ADDR_W-1:0] addr;
    } resp_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BCAST = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/resp_bus_arbiter_picker.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_priority_picker #(
    parameter int NUM_AGENTS = 4,
    parameter int AGENT_W    = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1
) (
    input  logic [NUM_AGENTS-1:0] req,
    input  logic [AGENT_W-1:0]    rr_ptr,
    output logic                  found,
    output logic [AGENT_W-1:0]    winner
);

    // Walk the agents in rotated order; the first hit is the winner.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_AGENTS) idx = idx - NUM_AGENTS;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = AGENT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/resp_bus_arbiter.sv
// Response bus arbiter: round-robin grant, one-cycle registered broadcast,
// bus held idle while any agent signals busy.
module resp_bus_arbiter
    import cache_types::*;
#(
    parameter int NUM_AGENTS = 4,
    parameter int AGENT_W    = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic      [NUM_AGENTS-1:0]       resp_bus_req,
    input  resp_msg_t [NUM_AGENTS-1:0]       resp_bus_tx,
    input  logic      [NUM_AGENTS-1:0]       resp_bus_busy,
    output logic      [NUM_AGENTS-1:0]       resp_bus_gnt,
    output resp_msg_t                        resp_bus_msg
);

    arb_state_t            state_q, state_d;
    logic [AGENT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AGENT_W-1:0]    w_q, w_d;
    resp_msg_t             msg_q, msg_d;
    logic [NUM_AGENTS-1:0] gnt_q, gnt_d;

    logic                  pick_found;
    logic [AGENT_W-1:0]    pick_w;
    logic                  any_busy;

    assign any_busy = |resp_bus_busy;

    rr_priority_picker #(
        .NUM_AGENTS (NUM_AGENTS),
        .AGENT_W    (AGENT_W)
    ) u_picker (
        .req    (resp_bus_req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .winner (pick_w)
    );

    // Next state, pointer advance and latching of the winner's message.
    // gnt and msg.valid are set on entry to BCAST and cleared on leaving it,
    // so both outputs come straight from flops.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        w_d      = w_q;
        msg_d    = msg_q;
        gnt_d    = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found && !any_busy) begin
                    w_d         = pick_w;
                    msg_d       = resp_bus_tx[pick_w];
                    msg_d.valid = 1'b1;
                    gnt_d       = NUM_AGENTS'(1) << pick_w;
                    state_d     = ARB_BCAST;
                end
            end
            ARB_BCAST: begin
                msg_d.valid = 1'b0;
                rr_ptr_d    = (w_q == AGENT_W'(NUM_AGENTS - 1)) ? '0 : w_q + AGENT_W'(1);
                state_d     = any_busy ? ARB_HOLD : ARB_IDLE;
            end
            ARB_HOLD: begin
                if (!any_busy) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            w_q      <= '0;
            msg_q    <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            w_q      <= w_d;
            msg_q    <= msg_d;
            gnt_q    <= gnt_d;
        end
    end

    assign resp_bus_gnt = gnt_q;
    assign resp_bus_msg = msg_q;

endmodule

// File: tb/tb_resp_bus_arbiter.sv
// Directed bench for resp_bus_arbiter (NUM_AGENTS=4).
module tb_resp_bus_arbiter;
    import cache_types::*;

    localparam int N = 4;

    logic                 clk;
    logic                 rst_n;
    logic      [N-1:0]    req;
    resp_msg_t [N-1:0]    tx;
    logic      [N-1:0]    busy;
    logic      [N-1:0]    gnt;
    resp_msg_t            msg;

    int n_chk;
    int n_err;

    resp_bus_arbiter #(.NUM_AGENTS(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .resp_bus_req  (req),
        .resp_bus_tx   (tx),
        .resp_bus_busy (busy),
        .resp_bus_gnt  (gnt),
        .resp_bus_msg  (msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic resp_msg_t mk(input int src, input mmsg_t m, input logic [31:0] a);
        resp_msg_t r;
        r       = '0;
        r.src   = SRC_W'(src);
        r.mmsg  = m;
        r.addr  = a;
        return r;
    endfunction

    // Advance one clock; leave time 1 unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        busy  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Bus invariants sampled on the falling edge.
    logic prev_valid;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_onehot0", {63'd0, $onehot0(gnt)}, 64'd1);
            if (prev_valid) chk("valid_back_to_back", {63'd0, msg.valid}, 64'd0);
            prev_valid <= msg.valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < N; i++) tx[i] = mk(i, MMSG_ACK, 32'h100 + i);

        // Reset state
        rst_n = 1'b0; req = '0; busy = '0;
        #3;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_valid", {63'd0, msg.valid}, 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
        chk("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        do_reset();

        // Single request from agent 2
        tx[2] = mk(2, MMSG_DATA, 32'h40);
        req   = 4'b0100;
        tick();
        chk("single_gnt", 64'(gnt), 64'b0100);
        chk("single_valid", {63'd0, msg.valid}, 64'd1);
        chk("single_addr", 64'(msg.addr), 64'h40);
        chk("single_mmsg", 64'(msg.mmsg), 64'(MMSG_DATA));
        req = '0;
        tick();
        chk("single_valid_off", {63'd0, msg.valid}, 64'd0);
        chk("single_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);

        // All-request fairness from reset
        do_reset();
        for (int i = 0; i < N; i++) tx[i] = mk(i, MMSG_ACK, 32'h100 + i);
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            tick();
            chk($sformatf("fair_gnt_%0d", k), 64'(gnt), 64'(4'b0001 << k));
            chk($sformatf("fair_src_%0d", k), 64'(msg.src), 64'(k));
            chk($sformatf("fair_valid_%0d", k), {63'd0, msg.valid}, 64'd1);
            req[k] = 1'b0;
            tick();
            chk($sformatf("fair_idle_gnt_%0d", k), 64'(gnt), 64'd0);
        end
        chk("fair_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

        // Wrap-around: bring rr_ptr to 3 via agent 2, then reqs 1001
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        chk("wrap_rr_ptr_pre", 64'(dut.rr_ptr_q), 64'd3);
        req = 4'b1001;
        tick();
        chk("wrap_gnt_first", 64'(gnt), 64'b1000);
        req[3] = 1'b0;
        tick();
        tick();
        chk("wrap_gnt_second", 64'(gnt), 64'b0001);
        req[0] = 1'b0;
        tick();
        chk("wrap_rr_ptr_post", 64'(dut.rr_ptr_q), 64'd1);

        // Busy stall: agent 1 requests while agent 3 is busy
        req  = 4'b0010;
        busy = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("busy_stall_gnt_%0d", c), 64'(gnt), 64'd0);
        end
        busy = '0;
        tick();
        chk("busy_release_gnt", 64'(gnt), 64'b0010);
        // Busy raised during BCAST sends the arbiter into HOLD
        busy = 4'b0100;
        req  = '0;
        tick();
        chk("hold_state", 64'(dut.state_q), 64'(ARB_HOLD));
        chk("hold_gnt", 64'(gnt), 64'd0);
        chk("hold_valid", {63'd0, msg.valid}, 64'd0);
        req = 4'b0001;
        repeat (3) tick();
        chk("hold_stays", 64'(dut.state_q), 64'(ARB_HOLD));
        chk("hold_no_gnt", 64'(gnt), 64'd0);
        busy = '0;
        req  = '0;
        tick();
        chk("hold_exit_idle", 64'(dut.state_q), 64'(ARB_IDLE));

        // Winner drops req and changes tx mid-BCAST
        tx[0] = mk(0, MMSG_DATA, 32'hAA);
        req   = 4'b0001;
        tick();
        chk("latch_gnt", 64'(gnt), 64'b0001);
        tx[0] = mk(0, MMSG_NACK, 32'hBB);
        req   = '0;
        #2;
        chk("latch_addr", 64'(msg.addr), 64'hAA);
        chk("latch_mmsg", 64'(msg.mmsg), 64'(MMSG_DATA));
        chk("latch_valid", {63'd0, msg.valid}, 64'd1);
        tick();
        chk("latch_done_valid", {63'd0, msg.valid}, 64'd0);

        // Async reset during BCAST
        req = 4'b0100;
        tick();
        chk("arst_pre_gnt", 64'(gnt), 64'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 64'(gnt), 64'd0);
        chk("arst_valid", {63'd0, msg.valid}, 64'd0);
        chk("arst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        req = 4'b0110;
        #3;
        rst_n = 1'b1;
        tick();
        chk("arst_first_gnt", 64'(gnt), 64'b0010);
        chk("arst_first_src", 64'(msg.src), 64'd1);
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
